// File: rtl/division_unit.sv
// -----------------------------------------------------------------------------
// division_unit
//
// Multi-cycle radix-2 restoring integer divider, WIDTH-generic. Produces one
// quotient bit per clock. Supports unsigned and two's-complement operands,
// a busy/done handshake, divide-by-zero detection and asynchronous abort
// through reset_n.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset; clears all state and outputs
//   start        request, sampled when idle or in the completion cycle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled w/ start)
//   a, b         dividend / divisor (sampled with start)
//   q, r         registered quotient / remainder, held until next completion
//   busy         operation in progress (RUN or FIX)
//   done         one-cycle completion pulse; q/r/div_by_zero just updated
//   div_by_zero  registered; set on completion when the captured b was 0
//
// Latency: start sampled at edge k, q/r valid and done=1 from edge
// k+WIDTH+1. A zero divisor skips the iteration and completes at edge k+1.
// -----------------------------------------------------------------------------
module division_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Iteration datapath: rem holds the partial remainder, dvd starts as the
    // dividend magnitude and fills up with quotient bits from the LSB side.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;   // raw dividend, returned as r on /0
    logic [CW-1:0]    cnt_q, cnt_d;

    // Captured operation attributes.
    logic sm_q, sm_d;      // signed mode
    logic sa_q, sa_d;      // sign of a
    logic sb_q, sb_d;      // sign of b
    logic zero_q, zero_d;  // divisor was zero

    // Result registers.
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    // Operand conditioning at capture time.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Restoring step.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             last_step;

    always_comb begin
        a_neg = signed_mode & a[WIDTH-1];
        b_neg = signed_mode & b[WIDTH-1];
        // The most-negative value negates to itself, which is its correct
        // unsigned magnitude; overflow cases therefore need no special path.
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    always_comb begin
        // {rem, dvd} shifted left by one; only the top WIDTH+1 bits matter for
        // the trial subtraction. shifted < 2*divisor, so the sign of the
        // WIDTH+1-bit difference is exact.
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_raw_d = a_raw_q;
        cnt_d   = cnt_q;
        sm_d    = sm_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    sm_d    = signed_mode;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    zero_d  = (b == '0);
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    a_raw_d = a;
                    rem_d   = '0;
                    cnt_d   = '0;
                    // A zero divisor bypasses the iteration: one busy cycle,
                    // then the completion cycle loads the /0 result.
                    state_d = (b == '0) ? FIX : RUN;
                end
            end

            RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (zero_q) begin
                    q_d   = '1;
                    r_d   = a_raw_q;
                    dbz_d = 1'b1;
                end else begin
                    // Truncating division: quotient negative when the operand
                    // signs differ, remainder follows the dividend's sign.
                    q_d   = (sm_q && (sa_q != sb_q)) ? (~dvd_q + 1'b1) : dvd_q;
                    r_d   = (sm_q && sa_q) ? (~rem_q + 1'b1) : rem_q;
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_raw_q <= '0;
            cnt_q   <= '0;
            sm_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zero_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_raw_q <= a_raw_d;
            cnt_q   <= cnt_d;
            sm_q    <= sm_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    // Handshake outputs decode directly from the state register, so they are
    // glitch-free and mutually exclusive by construction.
    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division_unit.sv
module tb_division_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        d;
    } exp_t;

    logic        clock;
    logic        reset_n;

    logic        start32, sm32;
    logic [31:0] a32, b32, q32, r32;
    logic        busy32, done32, dbz32;

    logic        start8, sm8;
    logic [7:0]  a8, b8, q8, r8;
    logic        busy8, done8, dbz8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    division_unit #(.WIDTH(32)) u_div32 (
        .clock(clock), .reset_n(reset_n), .start(start32), .signed_mode(sm32),
        .a(a32), .b(b32), .q(q32), .r(r32), .busy(busy32), .done(done32),
        .div_by_zero(dbz32)
    );

    division_unit #(.WIDTH(8)) u_div8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .q(q8), .r(r8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] q, input logic [31:0] r, input logic d);
        exp_t e;
        e.q = q; e.r = r; e.d = d;
        sb.push_back(e);
    endtask

    // Reference model for the 32-bit instance (truncating division).
    task automatic model(input bit sm, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        if (b == 0) begin
            push(32'hFFFF_FFFF, a, 1'b1);
        end else if (sm) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                eq = a; er = 0;
            end else begin
                eq = $signed(a) / $signed(b);
                er = $signed(a) % $signed(b);
            end
            push(eq, er, 1'b0);
        end else begin
            push(a / b, a % b, 1'b0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one start cycle; returns #1 after the sampling edge k.
    task automatic launch(input bit w8, input bit sm, input logic [31:0] av, input logic [31:0] bv);
        if (w8) begin
            start8 = 1'b1; sm8 = sm; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = 1'b1; sm32 = sm; a32 = av; b32 = bv;
        end
        tick(1);
        start8  = 1'b0;
        start32 = 1'b0;
        chk("busy_at_k", {31'b0, (w8 ? busy8 : busy32)}, 32'd1);
    endtask

    // Count edges until done, then pop the scoreboard and compare.
    task automatic wait_done(input bit w8, input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!(w8 ? done8 : done32) && n < 200);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_low"}, {31'b0, (w8 ? busy8 : busy32)}, 32'd0);
        chk({tag, "_sb_nonempty"}, {31'b0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, w8 ? {24'b0, q8} : q32, e.q);
            chk({tag, "_r"}, w8 ? {24'b0, r8} : r32, e.r);
            chk({tag, "_dbz"}, {31'b0, (w8 ? dbz8 : dbz32)}, {31'b0, e.d});
        end
    endtask

    initial begin
        int          ndone;
        logic [31:0] ra, rb;
        bit          rs;

        reset_n = 1'b1;
        start32 = 0; sm32 = 0; a32 = 0; b32 = 0;
        start8  = 0; sm8  = 0; a8  = 0; b8  = 0;
        #2 reset_n = 1'b0;
        #10;
        chk("rst_q", q32, 0);
        chk("rst_r", r32, 0);
        chk("rst_busy", {31'b0, busy32}, 0);
        chk("rst_done", {31'b0, done32}, 0);
        chk("rst_dbz", {31'b0, dbz32}, 0);
        chk("rst_q8", {24'b0, q8}, 0);
        reset_n = 1'b1;
        tick(1);

        // start held high: back-to-back operations every WIDTH+2 cycles
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'd7; b32 = 32'd3;
        push(32'd2, 32'd1, 1'b0);
        push(32'd2, 32'd1, 1'b0);
        tick(1);
        wait_done(0, "held1", 33);
        wait_done(0, "held2", 34);
        start32 = 1'b0;

        launch(0, 1, 32'hFFFF_FFF9, 32'd2);
        push(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_done(0, "sneg_a", 33);

        launch(0, 1, 32'd7, 32'hFFFF_FFFE);
        push(32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_done(0, "sneg_b", 33);

        launch(0, 0, 32'hFFFF_FFF9, 32'd2);
        push(32'h7FFF_FFFC, 32'd1, 1'b0);
        wait_done(0, "ubig", 33);

        launch(0, 0, 32'd5, 32'd0);
        push(32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_done(0, "dbz_u", 1);

        launch(0, 1, 32'd5, 32'd0);
        push(32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_done(0, "dbz_s", 1);

        launch(0, 0, 32'd9, 32'd4);
        push(32'd2, 32'd1, 1'b0);
        wait_done(0, "after_dbz", 33);

        launch(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        push(32'h8000_0000, 32'd0, 1'b0);
        wait_done(0, "ovf", 33);

        // second start while busy is ignored; late operand changes too
        launch(0, 0, 32'd100, 32'd7);
        push(32'd14, 32'd2, 1'b0);
        tick(5);
        start32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
        tick(2);
        start32 = 1'b0;
        wait_done(0, "ignore_start", 26);

        // abort mid-RUN with reset
        launch(0, 0, 32'd100, 32'd7);
        tick(10);
        reset_n = 1'b0;
        #1;
        chk("abort_q", q32, 0);
        chk("abort_r", r32, 0);
        chk("abort_busy", {31'b0, busy32}, 0);
        chk("abort_done", {31'b0, done32}, 0);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            tick(1);
            if (done32) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        launch(0, 0, 32'd9, 32'd3);
        push(32'd3, 32'd0, 1'b0);
        wait_done(0, "post_abort", 33);

        // randomised operations against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            rs = i[0];
            launch(0, rs, ra, rb);
            model(rs, ra, rb);
            wait_done(0, "rand", (rb == 0) ? 1 : 33);
        end

        // WIDTH=8 instance
        launch(1, 0, 32'd200, 32'd7);
        push(32'd28, 32'd4, 1'b0);
        wait_done(1, "w8_u", 9);

        launch(1, 1, 32'h80, 32'hFF);
        push(32'h80, 32'd0, 1'b0);
        wait_done(1, "w8_ovf", 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
